dmem_port_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 = core load/store,

---
 rtl/dmem_port_arbiter_pkg.sv | 16 +
 rtl/dmem_port_arbiter_rr_arbiter2.sv | 40 ++++
 rtl/dmem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Port indices are 1-bit so they can index grant vectors and compare with owner.
package dmem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. The pointer names the port that wins a tie and
// moves to the loser of every grant, so a lone requester always wins.
module rr_arbiter2
  import dmem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt[PORT_CORE]) begin
      rr_ptr_d = PORT_LDR;
    end else if (gnt[PORT_LDR]) begin
      rr_ptr_d = PORT_CORE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= PORT_CORE;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port DMEM between the core (port 0) and the loader (port 1).
// One access per issue cycle, at most one read in flight, read data routed to its owner.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            core_stall,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  output arb_state_e      dbg_state
);

  localparam int LCW = $clog2(MEM_LAT + 1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("dmem_port_arbiter: MEM_LAT must be in the range 1..4");
  end

  arb_state_e      state_q, state_d;
  logic [LCW-1:0]  lat_cnt_q, lat_cnt_d;
  logic            owner_q, owner_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            rd_done, can_issue, issue, sel, sel_we;
  logic [1:0]      gnt;

  // Grants are suppressed during reset so every output reads 0 while rst is high.
  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .en  (can_issue),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  always_comb begin
    rd_done   = (state_q == ARB_RD_WAIT) && (lat_cnt_q == LCW'(MEM_LAT));
    can_issue = !rst && ((state_q == ARB_IDLE) || rd_done);
    issue     = |gnt;
    sel       = gnt[PORT_LDR];
    sel_we    = sel ? m1_we : m0_we;

    m0_gnt    = gnt[PORT_CORE];
    m1_gnt    = gnt[PORT_LDR];

    mem_en    = issue;
    mem_we    = issue && sel_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (issue) begin
      mem_addr  = sel ? m1_addr  : m0_addr;
      mem_wdata = sel ? m1_wdata : m0_wdata;
      mem_be    = sel ? m1_be    : m0_be;
    end

    // Returned data is forwarded in the rvalid cycle and held afterwards.
    m0_rvalid = rd_done && (owner_q == PORT_CORE);
    m1_rvalid = rd_done && (owner_q == PORT_LDR);
    rdata0_d  = m0_rvalid ? mem_rdata : rdata0_q;
    rdata1_d  = m1_rvalid ? mem_rdata : rdata1_q;
    m0_rdata  = rdata0_d;
    m1_rdata  = rdata1_d;

    core_stall = !rst && ((m0_req && !m0_gnt) ||
                          ((state_q == ARB_RD_WAIT) && (owner_q == PORT_CORE) && !rd_done));

    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    if (state_q == ARB_RD_WAIT) begin
      if (rd_done) begin
        state_d   = ARB_IDLE;
        lat_cnt_d = '0;
      end else begin
        lat_cnt_d = lat_cnt_q + LCW'(1);
      end
    end
    // A read issued in the completion cycle re-enters RD_WAIT directly.
    if (issue && !sel_we) begin
      state_d   = ARB_RD_WAIT;
      lat_cnt_d = LCW'(1);
      owner_d   = sel;
    end

    dbg_state = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      lat_cnt_q <= '0;
      owner_q   <= PORT_CORE;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run scored
// against a byte-level memory model and transaction-level ordering rules.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int LAT = 3;
  localparam int MW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        core_stall, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  arb_state_e  dbg_state;
  logic [138:0] outs;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .core_stall(core_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  assign outs = {m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                 core_stall, mem_en, mem_we, mem_addr, mem_wdata, mem_be};

  // ---------------- memory model (fixed read latency LAT) ----------------
  logic [31:0] mem [MW];
  logic [31:0] rd_pipe [LAT];

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
      for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (mem_en && mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'h0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // ---------------- reference model: byte-addressed store ----------------
  logic [7:0] ref_bytes [4*MW];

  task automatic ref_reset();
    for (int i = 0; i < 4*MW; i++) ref_bytes[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_bytes[int'(a[7:2]) * 4 + b] = 8'(d >> (8 * b));
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r = r | (32'(ref_bytes[int'(a[7:2]) * 4 + b]) << (8 * b));
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
  endtask

  task automatic drive1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    ref_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    sample();
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    step();
    drive1(1'b0, 32'h08, 32'h0, 4'hF);
    sample();
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rst_first_gnt got %b exp 1", m1_gnt); end
    step();
    idle();
    repeat (LAT - 1) step();
    drive1(1'b0, 32'h0C, 32'h0, 4'hF);
    sample();
    checks++;
    if ({m1_rvalid, m1_gnt, m1_rdata} !== {2'b11, ref_read(32'h08)}) begin
      errors++; $display("FAIL rst_rvalid_and_gnt got %b%b %h exp 11 %h", m1_rvalid, m1_gnt, m1_rdata, ref_read(32'h08));
    end
    step();
    idle();
    #2;
    rst = 1;
    #1;
    checks++; if (outs !== '0) begin errors++; $display("FAIL rst_async_outs got %h exp 0", outs); end
    @(posedge clk);
    #1;
    rst = 0;
    ref_reset();
    for (int k = 0; k < LAT + 3; k++) begin
      sample();
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
        errors++; $display("FAIL rst_no_rvalid cyc %0d got %b%b exp 00", k, m0_rvalid, m1_rvalid);
      end
      step();
    end
  endtask

  task automatic test_core_write();
    int n_gnt;
    logic [31:0] d;
    drive0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    sample();
    checks++;
    if ({m0_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== {3'b111, 32'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL wr_issue got %b%b%b %h %h %h exp 111 10 deadbeef f",
                         m0_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be);
    end
    checks++; if ({core_stall, m0_rvalid} !== 2'b00) begin errors++; $display("FAIL wr_stall_rvalid got %b%b exp 00", core_stall, m0_rvalid); end
    ref_write(32'h10, 32'hDEADBEEF, 4'hF);
    n_gnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      d = $urandom;
      drive0(1'b1, 32'h20 + 32'(4 * k), d, 4'hF);
      sample();
      if (m0_gnt === 1'b1) n_gnt++;
      checks++; if ({core_stall, m0_rvalid} !== 2'b00) begin errors++; $display("FAIL b2b_stall_rvalid k %0d got %b%b exp 00", k, core_stall, m0_rvalid); end
      ref_write(32'h20 + 32'(4 * k), d, 4'hF);
    end
    checks++; if (n_gnt != 4) begin errors++; $display("FAIL b2b_grants got %0d exp 4", n_gnt); end
    step();
    idle();
  endtask

  task automatic test_core_read();
    drive0(1'b0, 32'h10, 32'h0, 4'hF);
    sample();
    checks++;
    if ({m0_gnt, mem_en, mem_we, core_stall} !== 4'b1100) begin
      errors++; $display("FAIL rd_issue got %b%b%b%b exp 1100", m0_gnt, mem_en, mem_we, core_stall);
    end
    for (int k = 1; k <= LAT; k++) begin
      step();
      idle();
      sample();
      checks++;
      if (k < LAT) begin
        if ({core_stall, m0_rvalid} !== 2'b10) begin
          errors++; $display("FAIL rd_wait k %0d got %b%b exp 10", k, core_stall, m0_rvalid);
        end
      end else if ({core_stall, m0_rvalid, m0_rdata} !== {2'b01, 32'hDEADBEEF}) begin
        errors++; $display("FAIL rd_return got %b%b %h exp 01 deadbeef", core_stall, m0_rvalid, m0_rdata);
      end
    end
    step();
    sample();
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_hold got %b %h exp 0 deadbeef", m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_alternate();
    logic exp0;
    do_reset();
    drive0(1'b1, 32'h40, 32'hA0A0_0001, 4'hF);
    drive1(1'b1, 32'h44, 32'hB0B0_0002, 4'hF);
    for (int k = 0; k < 8; k++) begin
      sample();
      exp0 = (k % 2 == 0);
      checks++;
      if ({m0_gnt, m1_gnt, core_stall} !== {exp0, !exp0, !exp0}) begin
        errors++; $display("FAIL alt_grant k %0d got %b%b%b exp %b%b%b", k, m0_gnt, m1_gnt, core_stall, exp0, !exp0, !exp0);
      end
      if (exp0) ref_write(32'h40, 32'hA0A0_0001, 4'hF);
      else ref_write(32'h44, 32'hB0B0_0002, 4'hF);
      step();
    end
    idle();
  endtask

  task automatic test_ldr_blocks_core();
    drive0(1'b1, 32'h48, 32'hC0C0_0003, 4'hF);
    sample();
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL blk_pre_gnt got %b exp 1", m0_gnt); end
    ref_write(32'h48, 32'hC0C0_0003, 4'hF);
    step();
    drive0(1'b1, 32'h4C, 32'hD0D0_0004, 4'hF);
    drive1(1'b0, 32'h44, 32'h0, 4'hF);
    sample();
    checks++;
    if ({m1_gnt, m0_gnt, core_stall} !== 3'b101) begin
      errors++; $display("FAIL blk_ldr_wins got %b%b%b exp 101", m1_gnt, m0_gnt, core_stall);
    end
    for (int k = 1; k <= LAT; k++) begin
      step();
      m1_req = 0;
      sample();
      checks++;
      if (k < LAT) begin
        if ({m0_gnt, core_stall, m1_rvalid} !== 3'b010) begin
          errors++; $display("FAIL blk_wait k %0d got %b%b%b exp 010", k, m0_gnt, core_stall, m1_rvalid);
        end
      end else if ({m1_rvalid, m0_gnt, core_stall, m1_rdata} !== {3'b110, ref_read(32'h44)}) begin
        errors++; $display("FAIL blk_release got %b%b%b %h exp 110 %h", m1_rvalid, m0_gnt, core_stall, m1_rdata, ref_read(32'h44));
      end
    end
    ref_write(32'h4C, 32'hD0D0_0004, 4'hF);
    step();
    idle();
  endtask

  task automatic test_byte_enable();
    drive0(1'b1, 32'h80, 32'h11223344, 4'hF);
    sample();
    ref_write(32'h80, 32'h11223344, 4'hF);
    step();
    drive0(1'b1, 32'h80, 32'hAABBCCDD, 4'b0101);
    sample();
    ref_write(32'h80, 32'hAABBCCDD, 4'b0101);
    step();
    drive0(1'b0, 32'h80, 32'h0, 4'hF);
    sample();
    checks++;
    if ({m0_gnt, mem_we} !== 2'b10) begin errors++; $display("FAIL be_rd_issue got %b%b exp 10", m0_gnt, mem_we); end
    step();
    idle();
    repeat (LAT - 1) step();
    sample();
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h11BB33DD}) begin
      errors++; $display("FAIL be_readback got %b %h exp 1 11bb33dd", m0_rvalid, m0_rdata);
    end
    checks++;
    if (mem[32] !== ref_read(32'h80)) begin errors++; $display("FAIL be_mem_word got %h exp %h", mem[32], ref_read(32'h80)); end
    step();
  endtask

  task automatic new_req0();
    drive0(1'($urandom_range(0, 1)), 32'($urandom_range(0, MW - 1)) << 2, $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic new_req1();
    drive1(1'($urandom_range(0, 1)), 32'($urandom_range(0, MW - 1)) << 2, $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic test_random();
    logic [48:0] exp_q[$];
    logic [48:0] head;
    logic        last_win, busy, due, stall_exp, g0p, g1p, w;
    logic [1:0]  exp_g, exp_rv;
    logic [69:0] exp_bus;
    logic [31:0] ea, ed, got_rd;
    logic [3:0]  ebe;
    logic        ewe;
    do_reset();
    last_win = 1'b1;
    g0p = 0;
    g1p = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (!m0_req || g0p) begin
        if (cyc < 560 && $urandom_range(0, 2) == 0) new_req0(); else m0_req = 1'b0;
      end
      if (!m1_req || g1p) begin
        if (cyc < 560 && $urandom_range(0, 3) == 0) new_req1(); else m1_req = 1'b0;
      end
      sample();
      busy = exp_q.size() != 0;
      head = busy ? exp_q[0] : '0;
      due  = busy && (head[47:32] == 16'(cyc));
      if (busy && !due) exp_g = 2'b00;
      else if (m0_req && m1_req) exp_g = last_win ? 2'b01 : 2'b10;
      else exp_g = {m1_req, m0_req};
      exp_rv = due ? (head[48] ? 2'b10 : 2'b01) : 2'b00;
      exp_bus = '0;
      if (exp_g[0]) exp_bus = {1'b1, m0_we, m0_addr, m0_wdata, m0_be};
      else if (exp_g[1]) exp_bus = {1'b1, m1_we, m1_addr, m1_wdata, m1_be};
      stall_exp = (m0_req && !exp_g[0]) || (busy && !due && !head[48]);
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_g) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b%b exp %b", cyc, m1_gnt, m0_gnt, exp_g); end
      checks++;
      if ({m1_rvalid, m0_rvalid} !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %b%b exp %b", cyc, m1_rvalid, m0_rvalid, exp_rv); end
      if (due) begin
        got_rd = head[48] ? m1_rdata : m0_rdata;
        checks++;
        if (got_rd !== head[31:0]) begin errors++; $display("FAIL rnd_rdata cyc %0d port %0d got %h exp %h", cyc, head[48], got_rd, head[31:0]); end
        void'(exp_q.pop_front());
      end
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== exp_bus) begin
        errors++; $display("FAIL rnd_bus cyc %0d got %h exp %h", cyc, {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, exp_bus);
      end
      checks++;
      if (core_stall !== stall_exp) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, core_stall, stall_exp); end
      g0p = exp_g[0];
      g1p = exp_g[1];
      if (exp_g != 2'b00) begin
        w = exp_g[1];
        last_win = w;
        ewe = w ? m1_we : m0_we;
        ea  = w ? m1_addr : m0_addr;
        ed  = w ? m1_wdata : m0_wdata;
        ebe = w ? m1_be : m0_be;
        if (ewe) ref_write(ea, ed, ebe);
        else exp_q.push_back({w, 16'(cyc + LAT), ref_read(ea)});
      end
    end
    step();
    idle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_core_write();
    test_core_read();
    test_alternate();
    test_ldr_blocks_core();
    test_byte_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
